ccff_chain_loader: RTL and testbench

Configuration-chain controller for the switch-block configuration flops. It accepts the bitstream as WORD_W-bit words over a valid/ready stream and serializes them onto `ccff_head` of a CHAIN_LEN-bit `ccff_head`→`ccff_tail` chain. It drives a shift enable that feeds the `prog_clk` clock gate of that chain. A readback mode recirculates the chain through `ccff_tail` so its contents can be inspected without being destroyed. The default CHAIN_LEN is 54, the bit count of one `sb_1__0_` tile.

---
 rtl/ccff_chain_loader.sv | 154 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ccff_chain_loader: streams config words onto a ccff chain, with recirculating readback.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 54,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_readback,
  output logic              cfg_busy,
  output logic              cfg_done,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_C    = CNT_W'(WORD_W);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT    = 3'd2,
    RB_SHIFT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  wordreg;
  logic [CNT_W-1:0]   word_left;
  logic [CNT_W-1:0]   bits_done;
  logic [WORD_W-1:0]  rb_acc;
  logic [IDX_W-1:0]   rb_idx;
  logic               rb_active;

  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   take;
  logic [WORD_W-1:0]  rb_word;
  logic               last_bit;

  always_comb begin
    remaining = LEN_C - bits_done;
    take      = (remaining < WORD_C) ? remaining : WORD_C;
    rb_word   = rb_acc | (WORD_W'(ccff_tail) << rb_idx);
    last_bit  = (bits_done == LAST_BIT);
  end

  // In readback the tail is looped straight back to the head so the chain rotates in place.
  assign ccff_head = rb_active ? ccff_tail : (ccff_shift_en & wordreg[0]);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= IDLE;
      wordreg       <= '0;
      word_left     <= '0;
      bits_done     <= '0;
      rb_acc        <= '0;
      rb_idx        <= '0;
      rb_active     <= 1'b0;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      s_ready       <= 1'b0;
      rb_data       <= '0;
      rb_valid      <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      rb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            bits_done <= '0;
            cfg_busy  <= 1'b1;
            if (cfg_readback) begin
              state         <= RB_SHIFT;
              rb_active     <= 1'b1;
              rb_acc        <= '0;
              rb_idx        <= '0;
              ccff_shift_en <= 1'b1;
            end else begin
              state   <= FETCH;
              s_ready <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (s_valid) begin
            wordreg       <= s_data;
            word_left     <= take;
            s_ready       <= 1'b0;
            ccff_shift_en <= 1'b1;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          wordreg   <= wordreg >> 1;
          word_left <= word_left - CNT_W'(1);
          bits_done <= bits_done + CNT_W'(1);
          if (word_left == CNT_W'(1)) begin
            ccff_shift_en <= 1'b0;
            if (last_bit) begin
              state    <= DONE;
              cfg_done <= 1'b1;
            end else begin
              state   <= FETCH;
              s_ready <= 1'b1;
            end
          end
        end
        RB_SHIFT: begin
          bits_done <= bits_done + CNT_W'(1);
          // A word is emitted when full, or zero-padded when the chain runs out.
          if ((rb_idx == LAST_IDX) || last_bit) begin
            rb_data  <= rb_word;
            rb_valid <= 1'b1;
            rb_acc   <= '0;
            rb_idx   <= '0;
          end else begin
            rb_acc <= rb_word;
            rb_idx <= rb_idx + IDX_W'(1);
          end
          if (last_bit) begin
            state         <= DONE;
            rb_active     <= 1'b0;
            ccff_shift_en <= 1'b0;
            cfg_done      <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader: randomized bench with a behavioural chain/bitstream model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 54;
  localparam int WORD_W    = 8;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              prog_clk = 1'b0;
  logic              pReset = 1'b1;
  logic              cfg_start = 1'b0;
  logic              cfg_readback = 1'b0;
  logic              cfg_busy;
  logic              cfg_done;
  logic [WORD_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(cfg_start), .cfg_readback(cfg_readback),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .rb_data(rb_data), .rb_valid(rb_valid), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters at the top, tail is bit 0.
  logic [CHAIN_LEN-1:0] chain = '0;
  assign ccff_tail = chain[0];
  always @(posedge prog_clk) if (ccff_shift_en === 1'b1) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_shift, n_hs, n_done, n_stall, n_bad_en, done_cyc, rb_last_cyc, entry, sum_stall;
  bit hs_now, busy_at_done, smp_busy, smp_en, smp_ready, smp_done;
  bit head_q[$];
  logic [WORD_W-1:0] rb_q[$];
  logic [WORD_W-1:0] words[NWORDS];
  int stalls[NWORDS];
  logic [CHAIN_LEN-1:0] exp_chain;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_shift = 0; n_hs = 0; n_done = 0; n_stall = 0; n_bad_en = 0;
    done_cyc = -1; rb_last_cyc = -1; busy_at_done = 0;
    head_q.delete(); rb_q.delete();
  endtask

  task automatic step();
    @(negedge prog_clk);
    cyc++;
    hs_now    = (s_ready === 1'b1) && s_valid;
    smp_busy  = (cfg_busy === 1'b1);
    smp_en    = (ccff_shift_en !== 1'b0);
    smp_ready = (s_ready === 1'b1);
    smp_done  = (cfg_done === 1'b1);
    if (ccff_shift_en === 1'b1) begin head_q.push_back(ccff_head); n_shift++; end
    if (hs_now) n_hs++;
    if (s_ready === 1'b1 && !s_valid) n_stall++;
    if (s_ready === 1'b1 && ccff_shift_en !== 1'b0) n_bad_en++;
    if (smp_done) begin n_done++; done_cyc = cyc; busy_at_done = smp_busy; end
    if (rb_valid === 1'b1) begin rb_q.push_back(rb_data); rb_last_cyc = cyc; end
    @(posedge prog_clk);
    #1;
  endtask

  // Bit i of the bitstream is bit (i mod W) of word (i / W); it lands in chain position i.
  function automatic logic [CHAIN_LEN-1:0] model_chain();
    logic [CHAIN_LEN-1:0] r;
    for (int i = 0; i < CHAIN_LEN; i++) r[i] = words[i / WORD_W][i % WORD_W];
    return r;
  endfunction

  task automatic do_load(input bit poke, input int abort_after);
    int idx, st, guard;
    clear_mon();
    cfg_start = 1; cfg_readback = 0;
    step();
    cfg_start = 0;
    entry = cyc + 1;
    idx = 0; st = stalls[0]; guard = 0;
    sum_stall = 0;
    for (int i = 0; i < NWORDS; i++) sum_stall += stalls[i];
    while (n_done == 0 && guard < 600) begin
      if (abort_after > 0 && n_shift >= abort_after) break;
      if (s_ready === 1'b1) begin
        if (st > 0) begin s_valid = 0; s_data = WORD_W'($urandom); st--; end
        else begin s_valid = 1; s_data = (idx < NWORDS) ? words[idx] : '0; end
      end else begin
        s_valid = 1'($urandom_range(0, 1)); s_data = WORD_W'($urandom);
      end
      cfg_start = poke && ($urandom_range(0, 5) == 0);
      cfg_readback = 1'($urandom_range(0, 1));
      step();
      guard++;
      if (hs_now) begin idx++; if (idx < NWORDS) st = stalls[idx]; end
    end
    s_valid = 0; cfg_start = 0;
  endtask

  task automatic check_load();
    logic [63:0] got;
    got = '0;
    for (int i = 0; i < head_q.size() && i < 64; i++) got[i] = head_q[i];
    exp_chain = model_chain();
    chk("load_handshakes", n_hs, NWORDS);
    chk("load_shifts", n_shift, CHAIN_LEN);
    chk("load_head_seq", got, exp_chain);
    chk("load_done_pulses", n_done, 1);
    chk("load_latency", done_cyc - entry, NWORDS + CHAIN_LEN + sum_stall);
    chk("load_stall_cycles", n_stall, sum_stall);
    chk("load_shift_en_in_fetch", n_bad_en, 0);
    chk("load_busy_at_done", busy_at_done, 1);
    chk("chain_after_load", chain, exp_chain);
    step();
    chk("busy_after_done", smp_busy, 0);
    chk("done_one_cycle", smp_done, 0);
  endtask

  task automatic do_readback(input bit poke);
    int guard;
    logic [WORD_W-1:0] w;
    clear_mon();
    cfg_start = 1; cfg_readback = 1;
    step();
    cfg_start = 0;
    entry = cyc + 1;
    guard = 0;
    while (n_done == 0 && guard < 200) begin
      s_valid = 1'($urandom_range(0, 1)); s_data = WORD_W'($urandom);
      cfg_start = poke && ($urandom_range(0, 5) == 0);
      cfg_readback = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    s_valid = 0; cfg_start = 0;
    chk("rb_shifts", n_shift, CHAIN_LEN);
    chk("rb_word_count", rb_q.size(), NWORDS);
    for (int k = 0; k < NWORDS; k++) begin
      w = '0;
      for (int j = 0; j < WORD_W; j++)
        if (k * WORD_W + j < CHAIN_LEN) w[j] = exp_chain[k * WORD_W + j];
      chk($sformatf("rb_word%0d", k), (k < rb_q.size()) ? rb_q[k] : 'x, w);
    end
    chk("rb_latency", done_cyc - entry, CHAIN_LEN);
    chk("rb_last_word_at_done", rb_last_cyc, done_cyc);
    chk("chain_after_rb", chain, exp_chain);
    step();
    chk("rb_busy_after_done", smp_busy, 0);
  endtask

  initial begin
    // Reset with random inputs; cfg_start in the final reset cycle.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'($urandom_range(0, 1)); s_data = WORD_W'($urandom);
      cfg_start = (i == 2); cfg_readback = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_rb_valid", rb_valid, 0);
    chk("rst_rb_data", rb_data, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    pReset = 0; cfg_start = 0; s_valid = 0;
    step();
    chk("start_during_reset_ignored", smp_busy, 0);
    step();

    // Directed load of the reference bitstream, then readback.
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'hD5};
    stalls = '{0, 0, 0, 0, 0, 0, 0};
    do_load(0, 0);
    check_load();
    do_readback(0);

    // Backpressure before words 2 and 5, with start pokes while busy.
    stalls = '{0, 0, 5, 0, 0, 5, 0};
    do_load(1, 0);
    check_load();
    do_readback(1);

    // Reset after 20 shifts, then a full load.
    for (int i = 0; i < NWORDS; i++) begin words[i] = WORD_W'($urandom); stalls[i] = 0; end
    do_load(0, 20);
    pReset = 1; s_valid = 1;
    step();
    pReset = 0; s_valid = 0;
    step();
    chk("midrst_shift_en", smp_en, 0);
    chk("midrst_busy", smp_busy, 0);
    chk("midrst_ready", smp_ready, 0);
    chk("midrst_no_done", n_done, 0);
    do_load(0, 0);
    check_load();
    do_readback(0);

    // Randomized loads and readbacks.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NWORDS; i++) begin
        words[i] = WORD_W'($urandom);
        stalls[i] = $urandom_range(0, 3);
      end
      do_load(1, 0);
      check_load();
      do_readback(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
